// File: rtl/ddr3_responder.sv
// rtl/ddr3_responder.sv - DDR3 DFI-side memory model: init sequencing, bank tracking, fixed-latency BL4 bursts
module ddr3_responder #(
  parameter int ROW_BITS = 2,
  parameter int RD_LAT   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dfi_csn,
  input  logic        dfi_rasn,
  input  logic        dfi_casn,
  input  logic        dfi_wen,
  input  logic [14:0] dfi_addr,
  input  logic [2:0]  dfi_bank,
  input  logic        dfi_cke,
  input  logic        dfi_rstn,
  input  logic [31:0] dfi_wdata,
  input  logic        dfi_wmask,
  output logic [31:0] dfi_rdata,
  output logic        init_done,
  output logic        proto_err,
  output logic [15:0] refresh_cnt
);

  localparam int AW    = 3 + ROW_BITS + 9;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] ST_RESET    = 2'd0;
  localparam logic [1:0] ST_WAIT_CKE = 2'd1;
  localparam logic [1:0] ST_MODE     = 2'd2;
  localparam logic [1:0] ST_READY    = 2'd3;

  localparam logic [1:0] B_IDLE = 2'd0;
  localparam logic [1:0] B_RD   = 2'd1;
  localparam logic [1:0] B_WR   = 2'd2;

  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;

  // Counter is 1 on the command edge, so beat i lands when cnt_q equals these plus i
  localparam logic [3:0] RD_FIRST = 4'(RD_LAT - 1);
  localparam logic [3:0] RD_LAST  = 4'(RD_LAT + 2);
  localparam logic [3:0] WR_FIRST = 4'(RD_LAT);
  localparam logic [3:0] WR_LAST  = 4'(RD_LAT + 3);

  logic [31:0] mem [DEPTH];

  logic [1:0]                init_q, init_d;
  logic [3:0]                mask_q, mask_d;
  logic                      done_q, done_d;
  logic                      perr_q, perr_d;
  logic [15:0]               ref_q, ref_d;
  logic [7:0]                open_q, open_d;
  logic [7:0][ROW_BITS-1:0]  row_q, row_d;
  logic [1:0]                bst_q, bst_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [2:0]                bbank_q, bbank_d;
  logic [ROW_BITS-1:0]       brow_q, brow_d;
  logic [6:0]                bcol_q, bcol_d;
  logic                      bap_q, bap_d;
  logic [31:0]               rdata_q, rdata_d;

  logic [3:0]    cmd;
  logic          busy;
  logic          ready;
  logic          mem_we;
  logic [1:0]    rd_beat;
  logic [1:0]    wr_beat;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          unused_addr;

  assign cmd         = {dfi_csn, dfi_rasn, dfi_casn, dfi_wen};
  assign busy        = (bst_q != B_IDLE);
  assign ready       = (init_q == ST_READY);
  assign rd_beat     = 2'(cnt_q - RD_FIRST);
  assign wr_beat     = 2'(cnt_q - WR_FIRST);
  assign rd_idx      = {bbank_q, brow_q, bcol_q, rd_beat};
  assign wr_idx      = {bbank_q, brow_q, bcol_q, wr_beat};
  assign unused_addr = ^{dfi_addr[14:11], dfi_addr[2:0]};

  always_comb begin
    init_d  = init_q;
    mask_d  = mask_q;
    done_d  = done_q;
    perr_d  = perr_q;
    ref_d   = ref_q;
    open_d  = open_q;
    row_d   = row_q;
    bst_d   = bst_q;
    cnt_d   = cnt_q;
    bbank_d = bbank_q;
    brow_d  = brow_q;
    bcol_d  = bcol_q;
    bap_d   = bap_q;
    rdata_d = '0;
    mem_we  = 1'b0;
    if (!dfi_rstn) begin
      init_d = ST_RESET;
      mask_d = '0;
      done_d = 1'b0;
      open_d = '0;
      bst_d  = B_IDLE;
      cnt_d  = '0;
    end else begin
      case (init_q)
        ST_RESET:    init_d = ST_WAIT_CKE;
        ST_WAIT_CKE: if (dfi_cke) init_d = ST_MODE;
        default: ;
      endcase

      if (busy) begin
        cnt_d = cnt_q + 4'd1;
        if (bst_q == B_RD && cnt_q >= RD_FIRST) rdata_d = mem[rd_idx];
        if (bst_q == B_WR && cnt_q >= WR_FIRST) begin
          if (dfi_wmask) mem_we = 1'b1;
          else           perr_d = 1'b1;
        end
        if ((bst_q == B_RD && cnt_q == RD_LAST) || (bst_q == B_WR && cnt_q == WR_LAST)) begin
          bst_d = B_IDLE;
          cnt_d = '0;
          if (bap_q) open_d[bbank_q] = 1'b0;
        end
      end

      if (dfi_cke) begin
        case (cmd)
          CMD_MRS: if (init_q == ST_MODE) mask_d[dfi_bank[1:0]] = 1'b1;
          CMD_ZQCL: begin
            if (mask_q != 4'hF) perr_d = 1'b1;
            else if (init_q == ST_MODE) begin
              init_d = ST_READY;
              done_d = 1'b1;
            end
          end
          CMD_ACT: begin
            if (!ready) perr_d = 1'b1;
            else if (busy && (open_q[dfi_bank] || dfi_bank == bbank_q)) perr_d = 1'b1;
            else begin
              if (open_q[dfi_bank]) perr_d = 1'b1;
              open_d[dfi_bank] = 1'b1;
              row_d[dfi_bank]  = dfi_addr[ROW_BITS-1:0];
            end
          end
          CMD_RD, CMD_WR: begin
            if (!ready || busy || !open_q[dfi_bank]) perr_d = 1'b1;
            else begin
              bst_d   = (cmd == CMD_RD) ? B_RD : B_WR;
              cnt_d   = 4'd1;
              bbank_d = dfi_bank;
              brow_d  = row_q[dfi_bank];
              bcol_d  = dfi_addr[9:3];
              bap_d   = dfi_addr[10];
            end
          end
          CMD_PRE: begin
            if (ready) begin
              if (busy)              perr_d = 1'b1;
              else if (dfi_addr[10]) open_d = '0;
              else                   open_d[dfi_bank] = 1'b0;
            end
          end
          CMD_REF: begin
            if (!ready || busy) perr_d = 1'b1;
            else begin
              ref_d = ref_q + 16'd1;
              if (|open_q) perr_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_q  <= ST_RESET;
      mask_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ref_q   <= '0;
      open_q  <= '0;
      row_q   <= '0;
      bst_q   <= B_IDLE;
      cnt_q   <= '0;
      bbank_q <= '0;
      brow_q  <= '0;
      bcol_q  <= '0;
      bap_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      init_q  <= init_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ref_q   <= ref_d;
      open_q  <= open_d;
      row_q   <= row_d;
      bst_q   <= bst_d;
      cnt_q   <= cnt_d;
      bbank_q <= bbank_d;
      brow_q  <= brow_d;
      bcol_q  <= bcol_d;
      bap_q   <= bap_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage survives every reset
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[wr_idx] <= dfi_wdata;
  end

  assign dfi_rdata   = rdata_q;
  assign init_done   = done_q;
  assign proto_err   = perr_q;
  assign refresh_cnt = ref_q;

endmodule

// File: tb/tb_ddr3_responder.sv
// tb/tb_ddr3_responder.sv - directed vector bench for ddr3_responder
module tb_ddr3_responder;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] MRS  = 4'b0000;
  localparam logic [3:0] ZQCL = 4'b0110;
  localparam logic [3:0] REF  = 4'b0001;
  localparam logic [3:0] ACT  = 4'b0011;
  localparam logic [3:0] RD   = 4'b0101;
  localparam logic [3:0] WR   = 4'b0100;
  localparam logic [3:0] PRE  = 4'b0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dfi_csn = 1'b0, dfi_rasn = 1'b1, dfi_casn = 1'b1, dfi_wen = 1'b1;
  logic [14:0] dfi_addr = '0;
  logic [2:0]  dfi_bank = '0;
  logic        dfi_cke = 1'b0;
  logic        dfi_rstn = 1'b0;
  logic [31:0] dfi_wdata = '0;
  logic        dfi_wmask = 1'b0;
  logic [31:0] dfi_rdata;
  logic        init_done;
  logic        proto_err;
  logic [15:0] refresh_cnt;

  int total  = 0;
  int passed = 0;

  ddr3_responder #(.ROW_BITS(2), .RD_LAT(6)) dut (
    .clk(clk), .rst(rst),
    .dfi_csn(dfi_csn), .dfi_rasn(dfi_rasn), .dfi_casn(dfi_casn), .dfi_wen(dfi_wen),
    .dfi_addr(dfi_addr), .dfi_bank(dfi_bank), .dfi_cke(dfi_cke), .dfi_rstn(dfi_rstn),
    .dfi_wdata(dfi_wdata), .dfi_wmask(dfi_wmask),
    .dfi_rdata(dfi_rdata), .init_done(init_done), .proto_err(proto_err),
    .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rstn, cke;
    logic [3:0]  cmd;
    logic [2:0]  bank;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic        wmask;
    logic [31:0] exp_rdata;
    logic        exp_done, exp_perr;
    logic [15:0] exp_ref;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, rn, ck, input logic [3:0] c, input logic [2:0] b,
                              input logic [14:0] a, input logic [31:0] wd, input logic wm,
                              input logic [31:0] er, input logic ed, ep, input logic [15:0] ef);
    vec_t v;
    v.rst = r; v.rstn = rn; v.cke = ck; v.cmd = c; v.bank = b; v.addr = a;
    v.wdata = wd; v.wmask = wm; v.exp_rdata = er; v.exp_done = ed; v.exp_perr = ep; v.exp_ref = ef;
    tbl.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [2:0] b, input logic [14:0] a,
                       input logic [31:0] wd, input logic wm);
    {dfi_csn, dfi_rasn, dfi_casn, dfi_wen} = c;
    dfi_bank = b; dfi_addr = a; dfi_wdata = wd; dfi_wmask = wm;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic init_seq(input int nmrs);
    logic [2:0] order [4] = '{3'd2, 3'd3, 3'd1, 3'd0};
    rst = 1'b0; dfi_rstn = 1'b0; dfi_cke = 1'b0; drive(NOP, 0, 0, 0, 0); step();
    dfi_rstn = 1'b1; step();
    dfi_cke = 1'b1; step();
    for (int i = 0; i < nmrs; i++) begin drive(MRS, order[i], 0, 0, 0); step(); end
    drive(ZQCL, 0, 0, 0, 0); step();
    drive(NOP, 0, 0, 0, 0);
  endtask

  task automatic do_rst();
    rst = 1'b1; drive(NOP, 0, 0, 0, 0); step(); rst = 1'b0;
  endtask

  logic [31:0] wb [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0] mb [4] = '{32'hAAAA0000, 32'hBBBB1111, 32'hCCCC2222, 32'hDDDD3333};

  initial begin
    // Reset, init, auto-precharged write then read of bank 3 row 1 col 0x010
    add(1, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, MRS, 2, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, MRS, 3, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, MRS, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, MRS, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, ZQCL, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, ACT, 3, 15'h001, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, WR, 3, 15'h410, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, NOP, 0, 0, wb[i], 1, 0, 1, 0, 0);
    add(0, 1, 1, ACT, 3, 15'h001, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, RD, 3, 15'h410, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, NOP, 0, 0, 0, 0, wb[i], 1, 0, 0);
    add(0, 1, 1, NOP, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, ACT, 3, 15'h001, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, PRE, 0, 15'h400, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, REF, 0, 0, 0, 0, 0, 1, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; dfi_rstn = tbl[i].rstn; dfi_cke = tbl[i].cke;
      drive(tbl[i].cmd, tbl[i].bank, tbl[i].addr, tbl[i].wdata, tbl[i].wmask);
      step();
      chk($sformatf("vec%0d_rdata", i), dfi_rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_done", i), {31'd0, init_done}, {31'd0, tbl[i].exp_done});
      chk($sformatf("vec%0d_perr", i), {31'd0, proto_err}, {31'd0, tbl[i].exp_perr});
      chk($sformatf("vec%0d_ref", i), {16'd0, refresh_cnt}, {16'd0, tbl[i].exp_ref});
    end

    // Missing wmask on beat 2 leaves the old word in place
    drive(ACT, 3, 15'h001, 0, 0); step();
    chk("wm_act_perr", {31'd0, proto_err}, 32'd0);
    drive(WR, 3, 15'h010, 0, 0); step();
    drive(NOP, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 4; i++) begin
      drive(NOP, 0, 0, mb[i], (i != 2));
      step();
      if (i == 1) chk("wm_beat1_perr", {31'd0, proto_err}, 32'd0);
      if (i == 2) chk("wm_beat2_perr", {31'd0, proto_err}, 32'd1);
    end
    drive(RD, 3, 15'h010, 0, 0); step();
    drive(NOP, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("wm_rd_beat%0d", i), dfi_rdata, (i == 2) ? wb[2] : mb[i]);
    end
    step();
    chk("wm_rd_after", dfi_rdata, 32'd0);

    // dfi_rstn drop mid-read
    drive(RD, 3, 15'h010, 0, 0); step();
    drive(NOP, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    chk("abort_beat0", dfi_rdata, mb[0]);
    dfi_rstn = 1'b0; step();
    chk("abort_rdata", dfi_rdata, 32'd0);
    chk("abort_done", {31'd0, init_done}, 32'd0);
    chk("abort_perr_kept", {31'd0, proto_err}, 32'd1);
    chk("abort_ref_kept", {16'd0, refresh_cnt}, 32'd1);
    step();
    chk("abort_rdata2", dfi_rdata, 32'd0);
    do_rst();
    chk("rst_perr", {31'd0, proto_err}, 32'd0);
    chk("rst_ref", {16'd0, refresh_cnt}, 32'd0);

    // READ to closed bank 5
    init_seq(4);
    chk("rd5_init_done", {31'd0, init_done}, 32'd1);
    drive(RD, 5, 15'h010, 0, 0); step();
    chk("rd5_perr", {31'd0, proto_err}, 32'd1);
    drive(NOP, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("rd5_rdata%0d", i), dfi_rdata, 32'd0);
    end
    do_rst();

    // ZQCL after only three MRS
    init_seq(3);
    chk("zq3_perr", {31'd0, proto_err}, 32'd1);
    chk("zq3_done", {31'd0, init_done}, 32'd0);
    do_rst();

    // Refresh counter wrap, then refresh with a bank open
    init_seq(4);
    drive(REF, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) step();
    chk("ref_ffff", {16'd0, refresh_cnt}, 32'h0000FFFF);
    step();
    chk("ref_wrap", {16'd0, refresh_cnt}, 32'd0);
    chk("ref_wrap_perr", {31'd0, proto_err}, 32'd0);
    drive(ACT, 0, 15'h000, 0, 0); step();
    drive(REF, 0, 0, 0, 0); step();
    chk("ref_open_perr", {31'd0, proto_err}, 32'd1);
    chk("ref_open_cnt", {16'd0, refresh_cnt}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
